// File: rtl/dffe_shift_window_pkg.sv
// dffe_window_pkg: shared constants, operation encoding and priority decode for the shift window
package dffe_window_pkg;
  localparam int BYTE = 8;
  typedef enum logic [1:0] {OP_NONE, OP_CLR, OP_SHIFT, OP_WRITE} op_e;
  function automatic int nbytes(int width);
    return width / BYTE;
  endfunction
  function automatic op_e op_decode(logic en, logic clr, logic shift, logic write);
    return !en ? OP_NONE : clr ? OP_CLR : shift ? OP_SHIFT : write ? OP_WRITE : OP_NONE;
  endfunction
endpackage

// File: rtl/dffe_shift_window_if.sv
// dffe_shift_window_if: control/data bundle of the shift window
//   master drives EN/CLR/SHIFT/WRITE/WADDR/BE/D/RADDR and observes Q_RD/Q_ALL/COUNT/FULL; slave is the window
interface dffe_shift_window_if import dffe_window_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH),
  parameter int CW = $clog2(DEPTH + 1)
);
  logic EN, CLR, SHIFT, WRITE;
  logic [AW-1:0] WADDR, RADDR;
  logic [nbytes(WIDTH)-1:0] BE;
  logic [WIDTH-1:0] D, Q_RD;
  logic [DEPTH*WIDTH-1:0] Q_ALL;
  logic [CW-1:0] COUNT;
  logic FULL;
  modport master(output EN, CLR, SHIFT, WRITE, WADDR, BE, D, RADDR, input Q_RD, Q_ALL, COUNT, FULL);
  modport slave(input EN, CLR, SHIFT, WRITE, WADDR, BE, D, RADDR, output Q_RD, Q_ALL, COUNT, FULL);
endinterface

// File: rtl/dffe_shift_window_byte_slice.sv
// dffe_byte_slice: 8-bit enable register with async active-low reset and zero/shift/write input mux
//   CLK, RST_N: clock and async reset; en: load enable; clr/shift: mux select (clr wins); sh_in/wr_in: data; q: state
module dffe_byte_slice import dffe_window_pkg::*; (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            en,
  input  logic            clr,
  input  logic            shift,
  input  logic [BYTE-1:0] sh_in,
  input  logic [BYTE-1:0] wr_in,
  output logic [BYTE-1:0] q
);
  logic [BYTE-1:0] q_d, q_q;
  always_comb q_d = clr ? '0 : shift ? sh_in : wr_in;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) q_q <= '0;
    else if (en) q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/dffe_shift_window.sv
// dffe_shift_window: DEPTH x WIDTH shift/write window with fill counter, built from byte slices
//   CLK, RST_N: clock and async active-low reset; s: window bus (controls in, Q_RD/Q_ALL/COUNT/FULL out)
module dffe_shift_window import dffe_window_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH),
  parameter int CW = $clog2(DEPTH + 1)
) (
  input logic CLK,
  input logic RST_N,
  dffe_shift_window_if.slave s
);
  localparam int NB = nbytes(WIDTH);
  op_e op;
  logic is_clr, is_shift, is_write, full;
  logic [DEPTH*WIDTH-1:0] all;
  logic [WIDTH-1:0] q_rd;
  logic [BYTE-1:0] cnt_q;
  assign op = op_decode(s.EN, s.CLR, s.SHIFT, s.WRITE);
  assign is_clr = op == OP_CLR;
  assign is_shift = op == OP_SHIFT;
  assign is_write = op == OP_WRITE;
  for (genvar i = 0; i < DEPTH; i++) begin : g_w
    for (genvar b = 0; b < NB; b++) begin : g_b
      logic [BYTE-1:0] prev;
      if (i == 0) begin : g_head
        assign prev = s.D[b*BYTE +: BYTE];
      end else begin : g_tail
        assign prev = all[(i-1)*WIDTH + b*BYTE +: BYTE];
      end
      // out-of-range WADDR matches no word, so such writes fall through as no-ops
      dffe_byte_slice u_slice (
        .CLK, .RST_N,
        .en(is_clr | is_shift | (is_write & s.WADDR == AW'(i) & s.BE[b])),
        .clr(is_clr), .shift(is_shift),
        .sh_in(prev), .wr_in(s.D[b*BYTE +: BYTE]),
        .q(all[i*WIDTH + b*BYTE +: BYTE])
      );
    end
  end
  // fill counter lives in one byte slice; full compares all 8 bits so DEPTH must stay below 256
  assign full = cnt_q == BYTE'(DEPTH);
  dffe_byte_slice u_count (
    .CLK, .RST_N,
    .en(is_clr | (is_shift & ~full)),
    .clr(is_clr), .shift(is_shift),
    .sh_in(cnt_q + 8'd1), .wr_in('0),
    .q(cnt_q)
  );
  always_comb begin
    q_rd = '0;
    for (int i = 0; i < DEPTH; i++) q_rd = s.RADDR == AW'(i) ? all[i*WIDTH +: WIDTH] : q_rd;
  end
  assign s.Q_RD = q_rd;
  assign s.Q_ALL = all;
  assign s.COUNT = cnt_q[CW-1:0];
  assign s.FULL = full;
endmodule

// File: tb/tb_dffe_shift_window.sv
// tb_dffe_shift_window: directed checks of shift, byte write, priority, gating, reset and read port
module tb_dffe_shift_window;
  import dffe_window_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errs = 0;
  int total = 0;
  always #5 clk = ~clk;
  dffe_shift_window_if #(.WIDTH(32), .DEPTH(16)) a();
  dffe_shift_window_if #(.WIDTH(32), .DEPTH(12)) c();
  dffe_shift_window #(.WIDTH(32), .DEPTH(16)) dut16 (.CLK(clk), .RST_N(rst_n), .s(a));
  dffe_shift_window #(.WIDTH(32), .DEPTH(12)) dut12 (.CLK(clk), .RST_N(rst_n), .s(c));
  task automatic check(string tag, logic [511:0] obs, logic [511:0] exp);
    total++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    {a.EN, a.CLR, a.SHIFT, a.WRITE} = '0;
    {c.EN, c.CLR, c.SHIFT, c.WRITE} = '0;
  endtask
  task automatic step();
    @(posedge clk);
    #1 idle();
  endtask
  task automatic op16(op_e op, logic [31:0] d, logic [3:0] addr = '0, logic [3:0] be = '0);
    a.EN = 1'b1;
    a.CLR = op == OP_CLR;
    a.SHIFT = op == OP_SHIFT;
    a.WRITE = op == OP_WRITE;
    a.D = d;
    a.WADDR = addr;
    a.BE = be;
    step();
  endtask
  task automatic op12(op_e op, logic [31:0] d, logic [3:0] addr = '0, logic [3:0] be = '0);
    c.EN = 1'b1;
    c.CLR = op == OP_CLR;
    c.SHIFT = op == OP_SHIFT;
    c.WRITE = op == OP_WRITE;
    c.D = d;
    c.WADDR = addr;
    c.BE = be;
    step();
  endtask
  initial begin
    idle();
    {a.D, a.WADDR, a.BE, a.RADDR} = '0;
    {c.D, c.WADDR, c.BE, c.RADDR} = '0;
    #12 rst_n = 1'b1;
    check("rst_qall", a.Q_ALL, '0);
    check("rst_count", a.COUNT, 0);
    check("rst_full", a.FULL, 0);
    for (int i = 1; i <= 5; i++) op16(OP_SHIFT, i);
    check("pre_rst_count", a.COUNT, 5);
    check("pre_rst_w4", a.Q_ALL[4*32 +: 32], 1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_qall", a.Q_ALL, '0);
    check("async_rst_count", a.COUNT, 0);
    check("async_rst_full", a.FULL, 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) op16(OP_SHIFT, i);
    check("fill_count", a.COUNT, 16);
    check("fill_full", a.FULL, 1);
    check("fill_w0", a.Q_ALL[0 +: 32], 16);
    check("fill_w15", a.Q_ALL[15*32 +: 32], 1);
    op16(OP_SHIFT, 17);
    check("sat_w0", a.Q_ALL[0 +: 32], 17);
    check("sat_w15", a.Q_ALL[15*32 +: 32], 2);
    check("sat_count", a.COUNT, 16);
    check("sat_full", a.FULL, 1);
    op16(OP_CLR, 32'hdead_beef);
    check("clr_qall", a.Q_ALL, '0);
    check("clr_count", a.COUNT, 0);
    op16(OP_SHIFT, 32'haabb_ccdd);
    op16(OP_SHIFT, 32'h10);
    op16(OP_SHIFT, 32'h20);
    op16(OP_SHIFT, 32'h30);
    check("load_w3", a.Q_ALL[3*32 +: 32], 32'haabb_ccdd);
    op16(OP_WRITE, 32'h1122_3344, 4'd3, 4'b0101);
    check("bwr_w3", a.Q_ALL[3*32 +: 32], 32'haa22_cc44);
    check("bwr_w0", a.Q_ALL[0 +: 32], 32'h30);
    check("bwr_count", a.COUNT, 4);
    op16(OP_WRITE, 32'hffff_ffff, 4'd0, 4'b0000);
    check("be0_w0", a.Q_ALL[0 +: 32], 32'h30);
    a.EN = 1'b1; a.SHIFT = 1'b1; a.WRITE = 1'b1; a.WADDR = 4'd0; a.BE = 4'hf; a.D = 32'h5;
    step();
    check("prio_w0", a.Q_ALL[0 +: 32], 32'h5);
    check("prio_w1", a.Q_ALL[1*32 +: 32], 32'h30);
    check("prio_w4", a.Q_ALL[4*32 +: 32], 32'haa22_cc44);
    check("prio_count", a.COUNT, 5);
    a.EN = 1'b1; a.CLR = 1'b1; a.SHIFT = 1'b1; a.D = 32'h9;
    step();
    check("clr_sh_qall", a.Q_ALL, '0);
    check("clr_sh_count", a.COUNT, 0);
    op16(OP_SHIFT, 32'h7);
    op16(OP_SHIFT, 32'h8);
    a.EN = 1'b0; a.CLR = 1'b1; a.SHIFT = 1'b1; a.WRITE = 1'b1; a.BE = 4'hf; a.D = 32'h55;
    repeat (3) @(posedge clk);
    #1 idle();
    check("en_qall", a.Q_ALL, {480'h0, 32'h7, 32'h8});
    check("en_count", a.COUNT, 2);
    op16(OP_CLR, 0);
    for (int i = 0; i < 16; i++) op16(OP_SHIFT, 32'h100 + i);
    for (int r = 0; r < 16; r++) begin
      a.RADDR = 4'(r);
      #1 check($sformatf("rd16_%0d", r), a.Q_RD, 32'h100 + 15 - r);
    end
    op12(OP_SHIFT, 32'h1);
    op12(OP_SHIFT, 32'h2);
    op12(OP_SHIFT, 32'h3);
    check("d12_count", c.COUNT, 3);
    c.RADDR = 4'd2;
    #1 check("d12_rd2", c.Q_RD, 32'h1);
    c.RADDR = 4'd13;
    #1 check("d12_rd13", c.Q_RD, 0);
    op12(OP_WRITE, 32'hffff_ffff, 4'd13, 4'hf);
    check("d12_oob_qall", c.Q_ALL, {288'h0, 32'h1, 32'h2, 32'h3});
    check("d12_oob_count", c.COUNT, 3);
    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end
endmodule
